jtag_debug_sysclk_bridge: RTL and testbench

System-clock half of a parametrised JTAG debug bridge. Synchronises the virtual-JTAG update strobes (vs_udr, vs_uir) from the TCK domain and captures the quasi-static shift register and IR into a small command queue. Pops commands to the CPU debug core through a valid/ready handshake, raising one-hot action / no-action pulses per IR code. Successor to the fixed 38-bit/2-bit-IR sysclk decoder: widths are generic, commands are queued rather than dropped, and overflow is reported.

---
 rtl/jtag_debug_sysclk_bridge_if.sv | 38 +++
 rtl/jtag_debug_sysclk_bridge.sv | 165 ++++++++++++++++
 tb/tb_jtag_debug_sysclk_bridge.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_debug_sysclk_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module     : jtag_debug_sysclk_bridge_if
//  Description: Command-side bundle between the JTAG sysclk bridge and the
//               CPU debug core. The bridge drives the head command and the
//               action pulses. The consumer drives cmd_ready.
//  Signals    : cmd_valid, cmd_ready, jdo[SR_W], cmd_ir[IR_W],
//               take_action[2**IR_W], take_no_action[2**IR_W],
//               cmd_ts[16] (only with JTAG_BRIDGE_TIMESTAMP_EN)
//  Revision   : 1.0 - initial release
// ============================================================================
interface jtag_debug_sysclk_bridge_if #(
  parameter int SR_W = 38,
  parameter int IR_W = 2
);
  localparam int N_CMD = 2**IR_W;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SR_W-1:0]  jdo;
  logic [IR_W-1:0]  cmd_ir;
  logic [N_CMD-1:0] take_action;
  logic [N_CMD-1:0] take_no_action;
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
  logic [15:0]      cmd_ts;

  modport master (output cmd_valid, jdo, cmd_ir, take_action, take_no_action, cmd_ts,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, jdo, cmd_ir, take_action, take_no_action, cmd_ts,
                  output cmd_ready);
`else
  modport master (output cmd_valid, jdo, cmd_ir, take_action, take_no_action,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, jdo, cmd_ir, take_action, take_no_action,
                  output cmd_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/jtag_debug_sysclk_bridge.sv
`default_nettype none
// ============================================================================
//  Module     : jtag_debug_sysclk_bridge
//  Description: System-clock half of the JTAG debug bridge. Synchronises the
//               TCK-domain update strobes, queues {ir_in, sr} on each
//               update-DR edge and hands commands to the debug core with a
//               valid/ready handshake plus one-hot action pulses.
//  Ports      : clk, reset_n (async, active low)
//               ir_in, sr, vs_udr, vs_uir  - TCK-domain inputs
//               clr_overflow              - clears the overflow sticky
//               cmd (master modport)      - head command, handshake, pulses
//               uir_pulse                 - one pulse per update-IR edge
//               cmd_count, overflow       - queue status
//  Options    : JTAG_BRIDGE_TIMESTAMP_EN adds a 16-bit capture timestamp per
//               entry, presented on cmd.cmd_ts.
//  Revision   : 1.0 - initial release
// ============================================================================
module jtag_debug_sysclk_bridge #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  input  wire logic [IR_W-1:0]          ir_in,
  input  wire logic [SR_W-1:0]          sr,
  input  wire logic                     vs_udr,
  input  wire logic                     vs_uir,
  input  wire logic                     clr_overflow,
  jtag_debug_sysclk_bridge_if.master    cmd,
  output logic                          uir_pulse,
  output logic [$clog2(DEPTH):0]        cmd_count,
  output logic                          overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int N_CMD = 2**IR_W;
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
  localparam int ENT_W = 16 + IR_W + SR_W;
`else
  localparam int ENT_W = IR_W + SR_W;
`endif

  // ---------------- strobe synchronisers ----------------
  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_hist_q, uir_hist_q;
  logic                   udr_rise, uir_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_hist_q <= 1'b0;
      uir_hist_q <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
      uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
    end
  end

  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;

  // ---------------- command queue ----------------
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [ENT_W-1:0] pop_data_q, pop_data_d;
  logic [N_CMD-1:0] take_q, take_d, ntake_q, ntake_d;
  logic             uir_pulse_q;
  logic [ENT_W-1:0] wr_entry, head, view;
  logic             valid, full, pop, push, drop;

`ifdef JTAG_BRIDGE_TIMESTAMP_EN
  logic [15:0] ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + 16'd1;
  end

  assign wr_entry   = {ts_q, ir_in, sr};
  assign cmd.cmd_ts = view[SR_W+IR_W +: 16];
`else
  assign wr_entry   = {ir_in, sr};
`endif

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = valid & cmd.cmd_ready;
  // A push into a full queue still fits when the head leaves on the same edge.
  assign push  = udr_rise & (~full | pop);
  assign drop  = udr_rise & full & ~pop;
  assign head  = mem_q[rd_ptr_q];
  // Once empty, keep showing the last popped command rather than stale storage.
  assign view  = valid ? head : pop_data_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop_data_d = pop_data_q;
    take_d     = '0;
    ntake_d    = '0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      pop_data_d = head;
      if (head[ACT_BIT]) take_d[head[SR_W +: IR_W]]  = 1'b1;
      else               ntake_d[head[SR_W +: IR_W]] = 1'b1;
    end

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // A drop in the same cycle as a clear leaves the sticky set.
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      pop_data_q  <= '0;
      take_q      <= '0;
      ntake_q     <= '0;
      uir_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      pop_data_q  <= pop_data_d;
      take_q      <= take_d;
      ntake_q     <= ntake_d;
      uir_pulse_q <= uir_rise;
    end
  end

  // Storage needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign cmd.cmd_valid      = valid;
  assign cmd.jdo            = view[SR_W-1:0];
  assign cmd.cmd_ir         = view[SR_W +: IR_W];
  assign cmd.take_action    = take_q;
  assign cmd.take_no_action = ntake_q;
  assign uir_pulse          = uir_pulse_q;
  assign cmd_count          = count_q;
  assign overflow           = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_sysclk_bridge.sv
`default_nettype none
// ============================================================================
//  Module     : tb_jtag_debug_sysclk_bridge
//  Description: Directed bench for jtag_debug_sysclk_bridge with a queue-based
//               reference model compared on every falling clock edge, plus
//               literal expectations for the key scenarios.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_jtag_debug_sysclk_bridge;
  localparam int SR_W = 38, IR_W = 2, ACT_BIT = 35, SYNC_STAGES = 2, DEPTH = 4;
  localparam int N_CMD = 2**IR_W;
  localparam int E_W = IR_W + SR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset_n = 1'b0;
  logic [IR_W-1:0]           ir_in = '0;
  logic [SR_W-1:0]           sr = '0;
  logic                      vs_udr = 1'b0, vs_uir = 1'b0, clr_overflow = 1'b0;
  logic                      uir_pulse, overflow;
  logic [$clog2(DEPTH):0]    cmd_count;

  jtag_debug_sysclk_bridge_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

  jtag_debug_sysclk_bridge #(
    .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .SYNC_STAGES(SYNC_STAGES), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr),
    .vs_uir(vs_uir), .clr_overflow(clr_overflow), .cmd(cmd_if),
    .uir_pulse(uir_pulse), .cmd_count(cmd_count), .overflow(overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A strobe first sampled at edge k is seen as an edge at k+SYNC_STAGES:
  // keep a history of raw samples and detect the rise SYNC_STAGES edges back.
  logic [E_W-1:0]   mq[$];
  logic [E_W-1:0]   m_hold = '0;
  logic [N_CMD-1:0] m_ta = '0, m_tna = '0;
  bit               m_ovf = 0, m_uir = 0;
  bit               udr_h[SYNC_STAGES+2];
  bit               uir_h[SYNC_STAGES+2];
  bit               m_pop, m_push, m_full;
  logic [E_W-1:0]   m_head;
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
  logic [15:0]      m_ts = '0, m_hold_ts = '0;
  logic [15:0]      mts[$];
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_hold = '0; m_ta = '0; m_tna = '0; m_ovf = 0; m_uir = 0;
      for (int i = 0; i < SYNC_STAGES+2; i++) begin udr_h[i] = 0; uir_h[i] = 0; end
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
      m_ts = '0; m_hold_ts = '0; mts.delete();
`endif
    end else begin
      for (int i = SYNC_STAGES+1; i > 0; i--) begin
        udr_h[i] = udr_h[i-1];
        uir_h[i] = uir_h[i-1];
      end
      udr_h[0] = vs_udr;
      uir_h[0] = vs_uir;
      m_push = udr_h[SYNC_STAGES] && !udr_h[SYNC_STAGES+1];
      m_uir  = uir_h[SYNC_STAGES] && !uir_h[SYNC_STAGES+1];
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() > 0) && cmd_if.cmd_ready;
      m_ta = '0; m_tna = '0;
      if (m_pop) begin
        m_head = mq.pop_front();
        m_hold = m_head;
        if (m_head[ACT_BIT]) m_ta[m_head[SR_W +: IR_W]] = 1'b1;
        else                 m_tna[m_head[SR_W +: IR_W]] = 1'b1;
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
        m_hold_ts = mts.pop_front();
`endif
      end
      if (m_push && m_full && !m_pop) m_ovf = 1;
      else begin
        if (m_push) begin
          mq.push_back({ir_in, sr});
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
          mts.push_back(m_ts);
`endif
        end
        if (clr_overflow) m_ovf = 0;
      end
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
      m_ts = m_ts + 16'd1;
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [E_W-1:0] exp_view;
  always @(negedge clk) begin
    if (mq.size() > 0) exp_view = mq[0];
    else               exp_view = m_hold;
    chk("valid", cmd_if.cmd_valid, (mq.size() > 0) ? 64'd1 : 64'd0);
    chk("count", cmd_count, 64'(mq.size()));
    chk("jdo", cmd_if.jdo, exp_view[SR_W-1:0]);
    chk("cmd_ir", cmd_if.cmd_ir, exp_view[SR_W +: IR_W]);
    chk("take_action", cmd_if.take_action, m_ta);
    chk("take_no_action", cmd_if.take_no_action, m_tna);
    chk("overflow", overflow, m_ovf);
    chk("uir_pulse", uir_pulse, m_uir);
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
    if (mq.size() > 0) chk("cmd_ts", cmd_if.cmd_ts, mts[0]);
    else               chk("cmd_ts", cmd_if.cmd_ts, m_hold_ts);
`endif
  end

  // ---------------- directed stimulus ----------------
  logic [SR_W-1:0] srs [5];
  logic [IR_W-1:0] irs [5];
  logic [N_CMD-1:0] onehot;
  int uir_seen;
`ifdef JTAG_BRIDGE_TIMESTAMP_EN
  logic [15:0] ts1, ts2;
`endif

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    repeat (3) tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop_one();
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    srs[0] = 38'h08_1111_1111; irs[0] = 2'd0;
    srs[1] = 38'h01_2222_2222; irs[1] = 2'd1;
    srs[2] = 38'h0F_3333_3333; irs[2] = 2'd2;
    srs[3] = 38'h00_4444_4444; irs[3] = 2'd3;
    srs[4] = 38'h08_5555_5555; irs[4] = 2'd2;

    repeat (3) tick();
    chk("rst_valid", cmd_if.cmd_valid, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_jdo", cmd_if.jdo, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_take", cmd_if.take_action, 0);
    reset_n = 1'b1;
    tick();

    // Long udr strobe: one push, two-edge latency.
    sr = 38'h2A_5555_AAAA; ir_in = 2'd1; vs_udr = 1'b1;
    tick();                                 // first sample edge N
    tick();                                 // N+1
    chk("lat_n1_valid", cmd_if.cmd_valid, 0);
    tick();                                 // N+2
    chk("lat_n2_valid", cmd_if.cmd_valid, 1);
    chk("first_jdo", cmd_if.jdo, 38'h2A_5555_AAAA);
    chk("first_ir", cmd_if.cmd_ir, 2'd1);
    chk("first_count", cmd_count, 1);
    repeat (7) tick();
    vs_udr = 1'b0;
    repeat (4) tick();
    chk("one_push_count", cmd_count, 1);

    // Pop with action bit set.
    pop_one();
    chk("pop_take", cmd_if.take_action, 4'b0010);
    chk("pop_notake", cmd_if.take_no_action, 4'b0000);
    chk("pop_count", cmd_count, 0);
    chk("pop_valid", cmd_if.cmd_valid, 0);
    chk("pop_hold_jdo", cmd_if.jdo, 38'h2A_5555_AAAA);
    tick();
    chk("pulse_one_cycle", cmd_if.take_action, 4'b0000);

    // Overflow: five strobes into a depth-4 queue.
    for (int i = 0; i < 5; i++) strobe(irs[i], srs[i]);
    chk("ovf_count", cmd_count, 4);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("order_jdo", cmd_if.jdo, srs[i]);
      chk("order_ir", cmd_if.cmd_ir, irs[i]);
      pop_one();
      onehot = '0;
      onehot[irs[i]] = 1'b1;
      if (srs[i][ACT_BIT]) chk("order_take", cmd_if.take_action, onehot);
      else                 chk("order_notake", cmd_if.take_no_action, onehot);
    end
    chk("drained_valid", cmd_if.cmd_valid, 0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full queue with a pop on the fifth push edge.
    for (int i = 0; i < 4; i++) strobe(irs[i], srs[i]);
    ir_in = irs[4]; sr = srs[4]; vs_udr = 1'b1;
    tick(); tick();
    cmd_if.cmd_ready = 1'b1;
    tick();                                 // push and pop together
    cmd_if.cmd_ready = 1'b0;
    chk("fullpop_count", cmd_count, 4);
    chk("fullpop_ovf", overflow, 0);
    vs_udr = 1'b0;
    repeat (3) tick();
    for (int i = 1; i < 5; i++) begin
      chk("fullpop_order", cmd_if.jdo, srs[i]);
      pop_one();
    end
    chk("fullpop_empty", cmd_count, 0);

    // uir strobe: one pulse, queue untouched.
    strobe(irs[1], srs[1]);
    uir_seen = 0;
    vs_uir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) vs_uir = 1'b0;
      tick();
      if (uir_pulse === 1'b1) uir_seen++;
    end
    chk("uir_once", 64'(uir_seen), 1);
    chk("uir_count", cmd_count, 1);

    // Reset with three entries queued flushes at once.
    strobe(irs[2], srs[2]);
    strobe(irs[3], srs[3]);
    chk("pre_rst_count", cmd_count, 3);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", cmd_if.cmd_valid, 0);
    chk("async_rst_count", cmd_count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

`ifdef JTAG_BRIDGE_TIMESTAMP_EN
    strobe(irs[0], srs[0]);
    ts1 = cmd_if.cmd_ts;
    pop_one();
    repeat (93) tick();
    strobe(irs[1], srs[1]);
    ts2 = cmd_if.cmd_ts;
    chk("ts_delta", ts2 - ts1, 16'd100);
    pop_one();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
